// File: rtl/vgather_stream_pkg.sv
// vgather_stream shared types and defaults.
// Element, lane and length types for the gather front end of the sum tree.
package vgather_stream_pkg;
  localparam int VS_DEF  = 16;
  localparam int INT_DEF = 16;

  typedef logic [INT_DEF-1:0]         elem_t;
  typedef logic [$clog2(VS_DEF)-1:0]  lane_t;
  typedef logic [$clog2(VS_DEF):0]    len_t;
  typedef elem_t [VS_DEF-1:0]         vec_t;

  function automatic int tree_latency(input int vs);
    return $clog2(vs);
  endfunction
endpackage

// File: rtl/vgather_stream_if.sv
// Stream-in / vector-out bundle of vgather_stream.
// master drives the element stream; slave is the gather block.
interface vgather_stream_if
  import vgather_stream_pkg::*;
#(
  parameter int VECTOR_SIZE = VS_DEF,
  parameter int INT_SIZE    = INT_DEF
);
  localparam int LW = $clog2(VECTOR_SIZE);

  logic [INT_SIZE-1:0]                  in_data;
  logic                                 in_valid;
  logic                                 in_last;
  logic                                 flush;
  logic                                 in_ready;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] x;
  logic                                 x_valid;
  logic                                 y_valid;
  logic [LW:0]                          y_len;

  modport master (
    output in_data, in_valid, in_last, flush,
    input  in_ready, x, x_valid, y_valid, y_len
  );

  modport slave (
    input  in_data, in_valid, in_last, flush,
    output in_ready, x, x_valid, y_valid, y_len
  );
endinterface

// File: rtl/vgather_stream_tag_delay.sv
// Async-reset shift register that carries the {valid,len} tag
// alongside the reduce tree so results come out framed.
module vgather_stream_tag_delay #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH-1:0][W-1:0] sr_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vgather_stream.sv
// Packs a serial element stream into zero-padded vectors for the
// reduce-sum tree and frames the tree output with y_valid/y_len.
module vgather_stream
  import vgather_stream_pkg::*;
#(
  parameter int VECTOR_SIZE = VS_DEF,
  parameter int INT_SIZE    = INT_DEF,
  parameter int LATENCY     = tree_latency(VECTOR_SIZE)
) (
  input  logic            clock,
  input  logic            resetn,
  vgather_stream_if.slave io
);
  localparam int LW = $clog2(VECTOR_SIZE);

  typedef logic [LW-1:0] lanew_t;
  typedef logic [LW:0]   lenw_t;
  typedef logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] vecw_t;

  vecw_t  fill_q, fill_d, merged;
  vecw_t  x_q, x_d;
  lanew_t lane_q, lane_d;
  lenw_t  len_q, len_d, used;
  logic   xv_q, xv_d;
  logic   rdy_q;
  logic   accept, emit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fill_q <= '0;
      x_q    <= '0;
      lane_q <= '0;
      len_q  <= '0;
      xv_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      x_q    <= x_d;
      lane_q <= lane_d;
      len_q  <= len_d;
      xv_q   <= xv_d;
      rdy_q  <= 1'b1;
    end
  end

  always_comb begin
    accept = io.in_valid & rdy_q;
    merged = fill_q;
    if (accept) merged[lane_q] = io.in_data;
    used = lenw_t'(lane_q) + lenw_t'(accept);
    // empty flush never emits, so a zero-length vector cannot exist
    emit = (accept & ((lane_q == lanew_t'(VECTOR_SIZE-1)) | io.in_last))
         | (io.flush & ((lane_q != '0) | accept));
  end

  always_comb begin
    x_d    = x_q;
    fill_d = merged;
    lane_d = lane_q + lanew_t'(accept);
    xv_d   = 1'b0;
    len_d  = '0;
    unique case (1'b1)
      emit: begin
        x_d    = merged;
        fill_d = '0;
        lane_d = '0;
        xv_d   = 1'b1;
        len_d  = used;
      end
      default: ;
    endcase
  end

  vgather_stream_tag_delay #(
    .DEPTH(LATENCY),
    .W    (LW + 2)
  ) u_tag (
    .clock (clock),
    .resetn(resetn),
    .d_i   ({xv_q, len_q}),
    .q_o   ({io.y_valid, io.y_len})
  );

  assign io.in_ready = rdy_q;
  assign io.x        = x_q;
  assign io.x_valid  = xv_q;
endmodule

// File: tb/tb_vgather_stream.sv
// Scoreboard bench for vgather_stream with a behavioural 4-stage
// reduce-sum tree standing in for vreducesum.
module tb_vgather_stream;
  import vgather_stream_pkg::*;

  logic clock;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;

  vgather_stream_if io ();

  vgather_stream u_dut (
    .clock (clock),
    .resetn(resetn),
    .io    (io.slave)
  );

  typedef struct {
    vec_t  vec;
    elem_t sum;
    len_t  len;
  } xexp_t;

  typedef struct {
    elem_t sum;
    len_t  len;
    int    due;
  } yexp_t;

  xexp_t xq[$];
  yexp_t yq[$];
  int    ytimes[$];

  elem_t tp[4];
  elem_t ymodel;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic elem_t vsum(input vec_t v);
    elem_t s = '0;
    for (int i = 0; i < VS_DEF; i++) s = s + v[i];
    return s;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) tp[i] <= '0;
    end else begin
      tp[0] <= vsum(io.x);
      for (int i = 1; i < 4; i++) tp[i] <= tp[i-1];
    end
  end
  assign ymodel = tp[3];

  task automatic chk(input string n, input logic [255:0] a,
                     input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  always @(negedge clock) begin
    xexp_t xe;
    yexp_t ye;
    if (!resetn) begin
      yq.delete();
    end else begin
      if (io.x_valid) begin
        if (xq.size() == 0) begin
          chk("x_unexpected", 1, 0);
        end else begin
          xe = xq.pop_front();
          chk("x_vec", io.x, xe.vec);
          ye.sum = xe.sum;
          ye.len = xe.len;
          ye.due = cyc + 4;
          yq.push_back(ye);
        end
      end
      if (io.y_valid) begin
        ytimes.push_back(cyc);
        if (yq.size() == 0) begin
          chk("y_unexpected", 1, 0);
        end else begin
          ye = yq.pop_front();
          chk("y_due", cyc, ye.due);
          chk("y_len", io.y_len, ye.len);
          chk("y_sum", ymodel, ye.sum);
        end
      end
    end
  end

  task automatic exp_push(input vec_t v, input len_t l, input elem_t s);
    xexp_t e;
    e.vec = v;
    e.len = l;
    e.sum = s;
    xq.push_back(e);
  endtask

  task automatic drive(input elem_t d, input logic v,
                       input logic l, input logic f);
    io.in_data  = d;
    io.in_valid = v;
    io.in_last  = l;
    io.flush    = f;
    @(posedge clock);
    #1;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    chk({tag, "_rst_xv"}, io.x_valid, 0);
    chk({tag, "_rst_yv"}, io.y_valid, 0);
    chk({tag, "_rst_rdy"}, io.in_ready, 0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    chk({tag, "_rdy_up"}, io.in_ready, 1);
  endtask

  initial begin
    vec_t v;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    resetn      = 1'b0;
    io.in_data  = '0;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.flush    = 1'b0;
    idle(2);
    chk("rst_x", io.x, 0);
    chk("rst_xv", io.x_valid, 0);
    chk("rst_yv", io.y_valid, 0);
    chk("rst_ylen", io.y_len, 0);
    chk("rst_rdy", io.in_ready, 0);
    resetn = 1'b1;
    idle(1);
    chk("rdy_up", io.in_ready, 1);

    // full vector 1..16
    for (int i = 0; i < 16; i++) v[i] = elem_t'(i + 1);
    exp_push(v, 16, 16'd136);
    for (int i = 0; i < 16; i++) drive(elem_t'(i + 1), 1, 0, 0);
    chk("t1_xv_next", io.x_valid, 1);
    idle(8);

    // partial vector with in_last
    v = '0;
    v[0] = 16'd4;
    v[1] = 16'd6;
    exp_push(v, 2, 16'd10);
    drive(4, 1, 0, 0);
    drive(6, 1, 1, 0);
    idle(8);

    // continuous stream of ones
    for (int i = 0; i < 16; i++) v[i] = 16'd1;
    for (int k = 0; k < 3; k++) exp_push(v, 16, 16'd16);
    ytimes.delete();
    for (int i = 0; i < 48; i++) drive(1, 1, 0, 0);
    idle(8);
    chk("t3_ycount", ytimes.size(), 3);
    chk("t3_gap1", (ytimes.size() == 3) ? ytimes[1] - ytimes[0] : 0, 16);
    chk("t3_gap2", (ytimes.size() == 3) ? ytimes[2] - ytimes[1] : 0, 16);

    // flush after three elements
    v = '0;
    v[0] = 16'd2;
    v[1] = 16'd3;
    v[2] = 16'd5;
    exp_push(v, 3, 16'd10);
    drive(2, 1, 0, 0);
    drive(3, 1, 0, 0);
    drive(5, 1, 0, 0);
    drive(0, 0, 0, 1);
    idle(8);

    // flush with empty buffer
    drive(0, 0, 0, 1);
    idle(8);
    chk("t4_empty_flush", xq.size() + yq.size(), 0);

    // flush together with an accept
    v = '0;
    v[0] = 16'd1;
    v[1] = 16'd7;
    exp_push(v, 2, 16'd8);
    drive(1, 1, 0, 0);
    drive(7, 1, 0, 1);
    idle(8);

    // wrap, back-to-back then with gaps
    for (int i = 0; i < 16; i++) v[i] = 16'hFFFF;
    exp_push(v, 16, 16'hFFF0);
    exp_push(v, 16, 16'hFFF0);
    for (int i = 0; i < 16; i++) drive(16'hFFFF, 1, 0, 0);
    idle(6);
    for (int i = 0; i < 16; i++) begin
      drive(16'hFFFF, 1, 0, 0);
      idle($urandom_range(0, 3));
    end
    idle(8);

    // reset with nine elements buffered
    for (int i = 0; i < 9; i++) drive(elem_t'(i + 1), 1, 0, 0);
    do_reset("t6a");
    for (int i = 0; i < 16; i++) v[i] = elem_t'(i + 1);
    exp_push(v, 16, 16'd136);
    for (int i = 0; i < 16; i++) drive(elem_t'(i + 1), 1, 0, 0);
    idle(8);

    // reset with a tag in flight: its y must never appear
    v = '0;
    v[0] = 16'd42;
    exp_push(v, 1, 16'd42);
    drive(42, 1, 1, 0);
    idle(1);
    do_reset("t6b");
    idle(10);

    chk("end_xq_empty", xq.size(), 0);
    chk("end_yq_empty", yq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
